// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame out, ACK check.
// Both open-drain lines are driven through *_oe (1 = pull low, 0 = release to pull-up).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned FRAME_W = 9;
    localparam logic [IDX_W-1:0] STOP_IDX = IDX_W'(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [1:0]           clk_sync_q, clk_sync_d;
    logic [1:0]           dat_sync_q, dat_sync_d;
    logic                 clk_prev_q, clk_prev_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 dat_oe_q, dat_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic clk_s_c, dat_s_c, fe_c, timed_c, expire_c;

    // Two-flop synchronizers plus one history flop for falling-edge detection
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_sync_q[1];
    end

    assign clk_s_c  = clk_sync_q[1];
    assign dat_s_c  = dat_sync_q[1];
    assign fe_c     = clk_prev_q & ~clk_s_c;
    assign timed_c  = state_q inside {S_SEND, S_ACK, S_WAIT_IDLE};
    assign expire_c = timed_c && !fe_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        inh_cnt_d = inh_cnt_q;
        bit_idx_d = bit_idx_q;
        to_cnt_d  = to_cnt_q;
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (timed_c) begin
            to_cnt_d = fe_c ? '0 : to_cnt_q + TO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    frame_d   = {~^cmd_data, cmd_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_REQ: begin
                // Start bit stays on the data line once the clock is released
                dat_oe_d  = 1'b1;
                bit_idx_d = '0;
                to_cnt_d  = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (expire_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    dat_oe_d = dat_oe_q;
                    if (fe_c) begin
                        if (bit_idx_q == STOP_IDX) begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end else begin
                            dat_oe_d  = ~frame_q[bit_idx_q];
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            S_ACK: begin
                if (expire_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fe_c) begin
                    if (dat_s_c) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s_c && dat_s_c) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (expire_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            inh_cnt_q  <= '0;
            bit_idx_q  <= '0;
            to_cnt_q   <= '0;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            inh_cnt_q  <= inh_cnt_d;
            bit_idx_q  <= bit_idx_d;
            to_cnt_q   <= to_cnt_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device receives frames on an open-drain line model,
// frames and pulse timing are checked against a reference computed from the byte itself.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 200;
    localparam int          HALF = 40;
    // Line fall to the cycle the host acts on it: two sync flops plus the edge-detect history flop
    localparam int unsigned SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(clk), .nReset(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Pulse bookkeeping, sampled mid-cycle
    int unsigned done_cnt = 0, err_cnt = 0, both_cnt = 0, overlap_cnt = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (done && error) both_cnt++;
            if ((done || error) && busy) overlap_cnt++;
        end
    end

    // What the device model saw during the last transaction
    bit          dv_ok;
    int          dv_inh, dv_req;
    logic        dv_start;
    logic [9:0]  dv_bits;
    int unsigned dv_fall_cyc;

    // Reference frame as {stop, odd parity, D7..D0}
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = (($countones(b) % 2) == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Device side: measure the request, then clock out up to 11 falls; falls 1..10 sample on the rise
    task automatic device_rx(input int stop_after, input bit give_ack);
        int n;
        dv_ok = 1'b0; dv_inh = 0; dv_req = 0; dv_bits = '0; dv_start = 1'b1;
        n = 0;
        while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
        if (!ps2_clk_oe) return;
        while (ps2_clk_oe && !ps2_dat_oe && dv_inh < 1000) begin dv_inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_dat_oe && dv_req < 10) begin dv_req++; @(negedge clk); end
        if (ps2_clk_oe) return;
        dv_start = ps2_dat_in;
        dv_ok = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k > stop_after) return;
            dev_clk_low = 1'b1;
            if (k == 11 && give_ack) dev_dat_low = 1'b1;
            if (k == stop_after) dv_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) dv_bits[k-1] = ps2_dat_in;
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            if (k < 11) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        settle(3);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_led_cmd;
        int unsigned d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(8'hED);
        device_rx(11, 1'b1);
        settle(10);
        checks++;
        if (dv_ok !== 1'b1 || dv_inh != int'(INH) || dv_req != 1) begin
            failures++;
            $display("FAIL led_request: got ok=%0d inhibit=%0d req=%0d expected ok=1 inhibit=%0d req=1",
                     dv_ok, dv_inh, dv_req, INH);
        end
        checks++;
        if (dv_start !== 1'b0) begin
            failures++;
            $display("FAIL led_start_bit: got %b expected 0", dv_start);
        end
        checks++;
        if (dv_bits !== exp_frame(8'hED)) begin
            failures++;
            $display("FAIL led_frame: got %b expected %b", dv_bits, exp_frame(8'hED));
        end
        checks++;
        if (done_cnt != d0 + 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL led_pulses: got done=%0d error=%0d expected done=%0d error=%0d",
                     done_cnt - d0, err_cnt - e0, 1, 0);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            failures++;
            $display("FAIL led_idle: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_back_to_back;
        int unsigned d0;
        int n;
        d0 = done_cnt;
        cmd_data  = 8'hF4;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_data = 8'h00;
        device_rx(11, 1'b1);
        checks++;
        if (dv_ok !== 1'b1 || dv_bits !== exp_frame(8'hF4)) begin
            failures++;
            $display("FAIL b2b_frame_f4: got ok=%0d %b expected %b", dv_ok, dv_bits, exp_frame(8'hF4));
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done1: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b clk_oe=%b expected 1 1", busy, ps2_clk_oe);
        end
        cmd_valid = 1'b0;
        device_rx(11, 1'b1);
        settle(10);
        checks++;
        if (dv_ok !== 1'b1 || dv_inh != int'(INH) || dv_bits !== exp_frame(8'h00)) begin
            failures++;
            $display("FAIL b2b_frame_00: got ok=%0d inhibit=%0d %b expected inhibit=%0d %b",
                     dv_ok, dv_inh, dv_bits, INH, exp_frame(8'h00));
        end
        checks++;
        if (done_cnt != d0 + 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        int unsigned d0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(255));
            d0 = done_cnt;
            start_cmd(b);
            device_rx(11, 1'b1);
            settle(10);
            checks++;
            if (dv_ok !== 1'b1 || dv_bits !== exp_frame(b) || done_cnt != d0 + 1) begin
                failures++;
                $display("FAIL random_frame[%0d]: byte %h got %b done=%0d expected %b done=1",
                         i, b, dv_bits, done_cnt - d0, exp_frame(b));
            end
        end
    endtask

    task automatic test_no_ack;
        logic [7:0] b;
        int unsigned d0, e0;
        b = 8'($urandom_range(255));
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(b);
        device_rx(11, 1'b0);
        settle(10);
        checks++;
        if (dv_bits !== exp_frame(b)) begin
            failures++;
            $display("FAIL noack_frame: got %b expected %b", dv_bits, exp_frame(b));
        end
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL noack_pulses: got error=%0d done=%0d expected error=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            failures++;
            $display("FAIL noack_idle: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        int unsigned d0, e0;
        b = 8'($urandom_range(255));
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(b);
        device_rx(4, 1'b1);
        settle(int'(TMO) + 20);
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL timeout_pulses: got error=%0d done=%0d expected error=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (err_cyc != dv_fall_cyc + SYNC_LAT + TMO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d expected %0d cycles after line fall",
                     err_cyc - dv_fall_cyc, SYNC_LAT + TMO);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            failures++;
            $display("FAIL timeout_idle: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_ignore_valid;
        logic [7:0] a, b;
        int unsigned d0;
        a = 8'($urandom_range(255));
        b = a ^ 8'($urandom_range(1, 255));
        d0 = done_cnt;
        start_cmd(a);
        fork
            device_rx(11, 1'b1);
            begin
                repeat (int'(INH) + 1 + 60) @(negedge clk);
                cmd_data  = b;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        join
        settle(10);
        checks++;
        if (dv_bits !== exp_frame(a)) begin
            failures++;
            $display("FAIL ignore_valid_frame: got %b expected %b", dv_bits, exp_frame(a));
        end
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_valid_state: got done=%0d busy=%b expected done=1 busy=0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int unsigned d0;
        int n;
        b = 8'($urandom_range(255)) & 8'hFE;
        start_cmd(b);
        n = 0;
        while (!(busy && !ps2_clk_oe) && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got busy=%b dat_oe=%b expected 1 1", busy, ps2_dat_oe);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            failures++;
            $display("FAIL midreset_release: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        settle(5);
        b = 8'($urandom_range(255));
        d0 = done_cnt;
        start_cmd(b);
        device_rx(11, 1'b1);
        settle(10);
        checks++;
        if (dv_bits !== exp_frame(b) || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL midreset_after: got %b done=%0d expected %b done=1",
                     dv_bits, done_cnt - d0, exp_frame(b));
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (both_cnt != 0 || overlap_cnt != 0) begin
            failures++;
            $display("FAIL pulse_invariants: got both=%0d busy_overlap=%0d expected 0 0",
                     both_cnt, overlap_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_led_cmd();
        test_back_to_back();
        test_random();
        test_no_ack();
        test_timeout();
        test_ignore_valid();
        test_reset_mid();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter: the outbound half of the keyboard link that feeds scancode bytes (data/data_en) to the keypad entry FSMs.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the bidirectional PS/2 clock and data lines open-drain through output-enable signals, and reports ACK success or failure.
- Asserts busy for the whole transaction so the scancode receiver and the entry FSMs ignore line activity while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks the host holds PS2 clock low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum system clocks allowed between successive device clock falling edges, and also the limit for the final return to idle (15 ms at 50 MHz).

Ports:
- Clock  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- cmd_data  in  8  command byte to send.
- cmd_valid  in  1  start request; sampled only in IDLE.
- ps2_clk_in  in  1  raw PS2 clock line level (asynchronous).
- ps2_dat_in  in  1  raw PS2 data line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2 clock low; 0 = release (pull-up).
- ps2_dat_oe  out  1  1 = pull PS2 data low; 0 = release.
- busy  out  1  high from command accept until done or error.
- done  out  1  one-cycle pulse: device ACK received and lines returned to idle.
- error  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset asserted mid-transaction releases both lines immediately (asynchronous) and discards the command.
- Line sync: ps2_clk_in and ps2_dat_in each pass through 2 flip-flops. A falling edge (fe) is detected as synchronized clock previous=1, current=0. Only synchronized values are used.
- Odd parity: parity = ~^cmd_data, latched at accept.
- IDLE: busy=0, both oe=0. If cmd_valid=1, latch cmd_data, set busy=1 and go to INHIBIT on the next cycle. cmd_valid is ignored in every other state.
- INHIBIT: ps2_clk_oe=1. Count INHIBIT_CYCLES, then go to REQ.
- REQ: ps2_dat_oe=1 (start bit 0) while ps2_clk_oe stays 1, for exactly 1 cycle. Then release ps2_clk_oe and go to SEND with bit index 0 and the timeout counter cleared.
- SEND: on each fe the host presents the next bit.
  - fe 1 to 8: data bits D0 to D7, LSB first.
  - fe 9: parity bit.
  - fe 10: stop bit, ps2_dat_oe=0.
  - Presenting a bit value of 1 means ps2_dat_oe=0; a value of 0 means ps2_dat_oe=1.
  - After fe 10, go to ACK.
- ACK: on the next fe, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: error pulse, go to IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1 on the same cycle, then pulse done and go to IDLE.
- Timeout: the counter clears on entering SEND and on every fe, and increments otherwise in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- done and error are never asserted together. busy falls in the same cycle as the done or error pulse.
- The host never drives ps2_clk_oe outside INHIBIT and REQ, and never drives ps2_dat_oe outside REQ and SEND.
- A back-to-back command is accepted no earlier than the cycle after done or error. A cmd_valid held high restarts immediately from IDLE.

Test Plan:
- Bench settings for all cases: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. The device model clocks at 40 system clocks per half period.
- 0xED with ACK: clock held low for 20 cycles, then the data line shows 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACK 0 -> done pulse, busy low, error 0.
- 0xF4 and 0x00: device captures byte 0xF4 with parity 0, and byte 0x00 with parity 1 -> done on each; the two commands are sent back-to-back with cmd_valid held high.
- No ACK (device leaves data 1 on fe 11) -> one error pulse, both oe=0, busy=0, done never asserted.
- Device stops clocking after fe 4 -> error pulse exactly 200 cycles after fe 4, lines released.
- cmd_valid pulsed during SEND with a different byte -> ignored; the original byte is delivered intact.
- nReset asserted during SEND -> ps2_clk_oe=0, ps2_dat_oe=0, busy=0 in the same cycle. A new command after reset completes normally.
